spi_txn_arbiter: RTL and testbench

- Shares one SPI transaction engine (byte-level converter register read/write over the shared DAC/ADC SPI buses) between up to N requesters, e.g. host register access, boot-time config loader, periodic readback scanner.
- Round-robin grant with a valid/ready request handshake and a one-cycle response pulse.
- Watchdog timeout on the engine, and an enforced idle gap between transactions so chip selects deassert cleanly between converters.

---
 rtl/spi_txn_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/spi_txn_arbiter.sv | 126 ++++++++++++
 tb/tb_spi_txn_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_txn_pkg.sv
// Shared definitions for the SPI transaction arbiter: FSM state encoding,
// transfer direction constants and the converter port width.
package spi_txn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam logic SPI_RW_READ  = 1'b0;
  localparam logic SPI_RW_WRITE = 1'b1;

  localparam int SPI_PORT_W = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first active
// request found searching upward from ptr, wrapping past NUM_REQ-1.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int PW = $clog2(NUM_REQ);

  logic found;
  int   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx[PW-1:0];
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one SPI transaction engine between NUM_REQ requesters with
// round-robin grant, an engine watchdog and an idle gap between transactions.
module spi_txn_arbiter
  import spi_txn_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GAP_CYCLES     = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [SPI_PORT_W*NUM_REQ-1:0]   req_port,
  input  logic [NUM_REQ-1:0]              req_rw,
  input  logic [8*NUM_REQ-1:0]            req_addr,
  input  logic [8*NUM_REQ-1:0]            req_wdata,
  output logic [NUM_REQ-1:0]              resp_valid,
  output logic [7:0]                      resp_data,
  output logic                            resp_err,
  output logic                            eng_start,
  output logic [SPI_PORT_W-1:0]           eng_port,
  output logic                            eng_rw,
  output logic [7:0]                      eng_addr,
  output logic [7:0]                      eng_wdata,
  input  logic                            eng_done,
  input  logic [7:0]                      eng_rdata,
  output logic                            busy,
  output logic [7:0]                      stat_timeouts
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t          state, state_next;
  logic [PW-1:0]   rr_ptr, owner, grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic [TW-1:0]   wait_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            accept, timeout_hit, gap_done;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign accept = (state == ST_IDLE) && (|req_valid);
  // wait_cnt is about to reach TIMEOUT_CYCLES-1, so RESP lands exactly
  // TIMEOUT_CYCLES cycles after eng_start.
  assign timeout_hit = (wait_cnt == TW'(TIMEOUT_CYCLES - 2));
  assign gap_done    = (gap_cnt == GW'(GAP_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (eng_done || timeout_hit) state_next = ST_RESP;
      ST_RESP:  state_next = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
      ST_GAP:   if (gap_done) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == ST_IDLE) ? grant : '0;
    eng_start  = (state == ST_ISSUE);
    busy       = (state != ST_IDLE);
    resp_valid = '0;
    if (state == ST_RESP) resp_valid[owner] = 1'b1;
  end

  // Datapath: request latch, round-robin pointer, counters and response capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr        <= '0;
      owner         <= '0;
      eng_port      <= '0;
      eng_rw        <= 1'b0;
      eng_addr      <= '0;
      eng_wdata     <= '0;
      wait_cnt      <= '0;
      gap_cnt       <= '0;
      resp_data     <= '0;
      resp_err      <= 1'b0;
      stat_timeouts <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            eng_port  <= req_port[int'(grant_idx)*SPI_PORT_W +: SPI_PORT_W];
            eng_rw    <= req_rw[grant_idx];
            eng_addr  <= req_addr[int'(grant_idx)*8 +: 8];
            eng_wdata <= req_wdata[int'(grant_idx)*8 +: 8];
            owner     <= grant_idx;
            rr_ptr    <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          end
        end
        ST_ISSUE: wait_cnt <= '0;
        ST_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (eng_done) begin
            resp_data <= (eng_rw == SPI_RW_WRITE) ? 8'h00 : eng_rdata;
            resp_err  <= 1'b0;
          end else if (timeout_hit) begin
            resp_data <= 8'h00;
            resp_err  <= 1'b1;
            if (stat_timeouts != 8'hFF) stat_timeouts <= stat_timeouts + 1'b1;
          end
        end
        ST_RESP: gap_cnt <= '0;
        ST_GAP:  gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed self-checking bench for spi_txn_arbiter: write/read transactions,
// round-robin fairness, idle gap, watchdog timeouts and reset mid-transaction.
module tb_spi_txn_arbiter;
  import spi_txn_pkg::*;

  localparam int N   = 4;
  localparam int TO  = 64;
  localparam int GAP = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [2*N-1:0]  req_port = '0;
  logic [N-1:0]    req_rw = '0;
  logic [8*N-1:0]  req_addr = '0;
  logic [8*N-1:0]  req_wdata = '0;
  logic [N-1:0]    resp_valid;
  logic [7:0]      resp_data;
  logic            resp_err;
  logic            eng_start;
  logic [1:0]      eng_port;
  logic            eng_rw;
  logic [7:0]      eng_addr;
  logic [7:0]      eng_wdata;
  logic            eng_done = 1'b0;
  logic [7:0]      eng_rdata = '0;
  logic            busy;
  logic [7:0]      stat_timeouts;

  int vectors = 0;
  int miscompares = 0;

  spi_txn_arbiter #(
    .NUM_REQ(N), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_port(req_port),
    .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .eng_start(eng_start), .eng_port(eng_port), .eng_rw(eng_rw),
    .eng_addr(eng_addr), .eng_wdata(eng_wdata),
    .eng_done(eng_done), .eng_rdata(eng_rdata),
    .busy(busy), .stat_timeouts(stat_timeouts)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic [1:0] port, input logic rw,
                               input logic [7:0] addr, input logic [7:0] wdata);
    req_valid[idx]          = 1'b1;
    req_port[2*idx +: 2]    = port;
    req_rw[idx]             = rw;
    req_addr[8*idx +: 8]    = addr;
    req_wdata[8*idx +: 8]   = wdata;
  endtask

  task automatic waitIdle;
    int n = 0;
    while (busy && n < 500) begin
      tick;
      n++;
    end
    checkOutput("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  task automatic waitResp(output int lat);
    lat = 0;
    while (resp_valid == '0 && lat < TO + 50) begin
      tick;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int gap_n;
    int bad_lat;
    logic [N-1:0] exp_grant;

    #1;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_eng_start", {31'd0, eng_start}, 32'd0);
    checkOutput("rst_stat", {24'd0, stat_timeouts}, 32'd0);
    checkOutput("rst_resp_valid", {28'd0, resp_valid}, 32'd0);
    tick;
    tick;
    reset = 1'b0;

    // Single write from requester 0
    applyStimulus(0, 2'd2, SPI_RW_WRITE, 8'h13, 8'hA5);
    #1;
    checkOutput("wr_ready", {28'd0, req_ready}, 32'h1);
    tick;
    req_valid = '0;
    checkOutput("wr_start", {31'd0, eng_start}, 32'd1);
    checkOutput("wr_port", {30'd0, eng_port}, 32'd2);
    checkOutput("wr_addr", {24'd0, eng_addr}, 32'h13);
    checkOutput("wr_wdata", {24'd0, eng_wdata}, 32'hA5);
    checkOutput("wr_rw", {31'd0, eng_rw}, 32'd1);
    tick;
    checkOutput("wr_start_one_cycle", {31'd0, eng_start}, 32'd0);
    repeat (49) tick;
    eng_done = 1'b1;
    eng_rdata = 8'hFF;
    tick;
    eng_done = 1'b0;
    checkOutput("wr_resp_valid", {28'd0, resp_valid}, 32'h1);
    checkOutput("wr_resp_data", {24'd0, resp_data}, 32'h0);
    checkOutput("wr_resp_err", {31'd0, resp_err}, 32'd0);
    tick;
    checkOutput("wr_resp_pulse", {28'd0, resp_valid}, 32'h0);
    waitIdle;
    checkOutput("eng_addr_held", {24'd0, eng_addr}, 32'h13);

    // Read from requester 2
    applyStimulus(2, 2'd1, SPI_RW_READ, 8'h05, 8'h00);
    #1;
    checkOutput("rd_ready", {28'd0, req_ready}, 32'h4);
    tick;
    req_valid = '0;
    checkOutput("rd_addr", {24'd0, eng_addr}, 32'h05);
    checkOutput("rd_rw", {31'd0, eng_rw}, 32'd0);
    checkOutput("rd_port", {30'd0, eng_port}, 32'd1);
    tick;
    repeat (5) tick;
    eng_done = 1'b1;
    eng_rdata = 8'h3C;
    tick;
    eng_done = 1'b0;
    checkOutput("rd_resp_valid", {28'd0, resp_valid}, 32'h4);
    checkOutput("rd_resp_data", {24'd0, resp_data}, 32'h3C);
    checkOutput("rd_resp_err", {31'd0, resp_err}, 32'd0);
    repeat (GAP) tick;
    checkOutput("rd_busy_in_gap", {31'd0, busy}, 32'd1);
    tick;
    checkOutput("rd_busy_drop", {31'd0, busy}, 32'd0);
    checkOutput("rd_data_held", {24'd0, resp_data}, 32'h3C);

    // Reset in IDLE to bring rr_ptr back to 0
    reset = 1'b1;
    tick;
    reset = 1'b0;

    // Fairness: all four requesters continuously valid, engine answers in 10 cycles
    for (int r = 0; r < N; r++) applyStimulus(r, r[1:0], SPI_RW_READ, 8'(8'h20 + r), 8'h00);
    #1;
    for (int t = 0; t < 6; t++) begin
      exp_grant = N'(1) << (t % N);
      checkOutput($sformatf("rr_grant_%0d", t), {28'd0, req_ready}, {28'd0, exp_grant});
      tick;
      checkOutput($sformatf("rr_start_%0d", t), {31'd0, eng_start}, 32'd1);
      tick;
      repeat (9) tick;
      eng_done = 1'b1;
      eng_rdata = 8'(8'h60 + t);
      tick;
      eng_done = 1'b0;
      checkOutput($sformatf("rr_resp_%0d", t), {28'd0, resp_valid}, {28'd0, exp_grant});
      if (t < 5) begin
        gap_n = 0;
        tick;
        while (req_ready == '0 && gap_n < 100) begin
          gap_n++;
          tick;
        end
        checkOutput($sformatf("rr_gap_%0d", t), gap_n, GAP);
      end
    end
    req_valid = '0;
    waitIdle;

    // First watchdog timeout
    applyStimulus(0, 2'd0, SPI_RW_READ, 8'h40, 8'h00);
    tick;
    req_valid = '0;
    waitResp(lat);
    checkOutput("to_latency", lat, TO);
    checkOutput("to_resp_valid", {28'd0, resp_valid}, 32'h1);
    checkOutput("to_resp_err", {31'd0, resp_err}, 32'd1);
    checkOutput("to_resp_data", {24'd0, resp_data}, 32'h0);
    checkOutput("to_stat_1", {24'd0, stat_timeouts}, 32'd1);
    waitIdle;

    // eng_done on the timeout cycle: done wins
    applyStimulus(0, 2'd0, SPI_RW_READ, 8'h41, 8'h00);
    tick;
    req_valid = '0;
    repeat (TO - 1) tick;
    eng_done = 1'b1;
    eng_rdata = 8'h5A;
    tick;
    eng_done = 1'b0;
    checkOutput("coinc_resp_valid", {28'd0, resp_valid}, 32'h1);
    checkOutput("coinc_resp_err", {31'd0, resp_err}, 32'd0);
    checkOutput("coinc_resp_data", {24'd0, resp_data}, 32'h5A);
    checkOutput("coinc_stat", {24'd0, stat_timeouts}, 32'd1);
    waitIdle;

    // 299 more timeouts: counter saturates at 255
    bad_lat = 0;
    for (int i = 2; i <= 300; i++) begin
      applyStimulus(0, 2'd0, SPI_RW_READ, 8'h42, 8'h00);
      tick;
      req_valid = '0;
      waitResp(lat);
      if (lat != TO || resp_err !== 1'b1) bad_lat++;
      if (i == 255) checkOutput("to_stat_255", {24'd0, stat_timeouts}, 32'd255);
      waitIdle;
    end
    checkOutput("to_latency_all", bad_lat, 0);
    checkOutput("to_stat_sat", {24'd0, stat_timeouts}, 32'd255);

    // Stray eng_done in IDLE is ignored
    eng_done = 1'b1;
    eng_rdata = 8'h77;
    tick;
    eng_done = 1'b0;
    checkOutput("stray_busy", {31'd0, busy}, 32'd0);
    checkOutput("stray_resp_valid", {28'd0, resp_valid}, 32'h0);
    tick;
    checkOutput("stray_resp_data", {24'd0, resp_data}, 32'h0);

    // Reset asserted while waiting on the engine
    applyStimulus(1, 2'd3, SPI_RW_READ, 8'h22, 8'h00);
    #1;
    checkOutput("rst_wait_ready", {28'd0, req_ready}, 32'h2);
    tick;
    req_valid = '0;
    tick;
    repeat (5) tick;
    checkOutput("rst_wait_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("rst_wait_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_wait_eng_addr", {24'd0, eng_addr}, 32'h0);
    checkOutput("rst_wait_stat", {24'd0, stat_timeouts}, 32'd0);
    checkOutput("rst_wait_resp_data", {24'd0, resp_data}, 32'h0);
    tick;
    tick;
    checkOutput("rst_wait_no_resp", {28'd0, resp_valid}, 32'h0);
    reset = 1'b0;
    applyStimulus(1, 2'd1, SPI_RW_READ, 8'h23, 8'h00);
    applyStimulus(3, 2'd3, SPI_RW_READ, 8'h24, 8'h00);
    #1;
    checkOutput("rst_ptr_grant", {28'd0, req_ready}, 32'h2);
    req_valid = '0;
    #1;
    checkOutput("drop_no_ready", {28'd0, req_ready}, 32'h0);
    tick;
    checkOutput("drop_no_accept", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
